prog_loader: RTL
================

Name: prog_loader

Overview:
- Writer side for the pipeline's instruction/data memory: loads a program image into a RAM write port over a byte stream, e.g. from a UART receiver.
- The image is a 16-bit word-count header followed by little-endian words.
- Each assembled word is written to consecutive word-aligned byte addresses, starting at 0.
- Holds the CPU in stall/flush (cpu_hold) while loading. The memory read ports address words with addr[WIDTH-1:2], so the loader emits byte addresses.

Parameters:
- WIDTH, 32, memory word and address width; must be a multiple of 8.
- LENGTH, 256, memory depth in words; the load capacity.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a load; honoured only in IDLE or DONE.
- s_valid  in  1  byte-stream valid.
- s_data  in  8  byte-stream data.
- s_ready  out  1  loader can accept a byte.
- wr_en  out  1  memory write strobe, one cycle per word.
- wr_addr  out  WIDTH  byte address of the write, always word-aligned (bits [1:0]=0).
- wr_data  out  WIDTH  assembled word.
- cpu_hold  out  1  high from start acceptance until DONE is reached; drives pipeline enable low and flush high.
- done  out  1  level, high in DONE until the next start or rst.
- err  out  1  sticky; header count exceeded LENGTH. Cleared on start or rst.
- words_written  out  16  count of wr_en pulses in the current load.

Behaviour:
- Byte transfer: a byte moves when s_valid && s_ready in the same cycle. s_data is sampled only then. s_valid may stay high across multiple transfers.
- States: IDLE, HDR_LO, HDR_HI, DATA, WRITE, DONE.
- IDLE:
  - On start: go to HDR_LO; clear err, words_written, byte counter and word index; cpu_hold=1.
- HDR_LO: on transfer, count[7:0]=s_data; go to HDR_HI.
- HDR_HI: on transfer, count[15:8]=s_data.
  - count==0: go to DONE.
  - count>LENGTH: set err.
  - Otherwise go to DATA.
- DATA: on transfer, place the byte at lane byte_cnt (lane 0 = bits [7:0], little-endian).
  - On the WIDTH/8-th byte: go to WRITE.
- WRITE (exactly one cycle, s_ready=0):
  - If idx<LENGTH: wr_en=1, wr_addr=idx<<2, wr_data=assembled word; increment words_written.
  - If idx>=LENGTH (overflow image): no write; the word is consumed and discarded.
  - Always increment idx.
  - If idx+1==count: go to DONE, else go to DATA.
- DONE: cpu_hold=0, done=1, s_ready=0.
  - start: behaves as in IDLE (reload).
- Outputs:
  - s_ready=1 only in HDR_LO, HDR_HI and DATA.
  - wr_en is combinational from state==WRITE (gated by idx<LENGTH). wr_addr and wr_data are stable in that cycle.
- Throughput: WIDTH/8 transfers plus 1 cycle per word. Header costs 2 transfers.
- start while in HDR_LO/HDR_HI/DATA/WRITE: ignored.
- rst (any cycle, including mid-word or in WRITE):
  - Go to IDLE. s_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=0, done=0, err=0, words_written=0.
  - A partially assembled word is dropped; memory contents already written are left as is.
- Widths:
  - idx and count are 16 bit.
  - wr_addr = zero-extended {idx,2'b00} truncated to WIDTH.
  - Comparison count>LENGTH is done at 17 bits.

Decomposition:
- Shared package loader_pkg:
  - enum loader_state_t {IDLE,HDR_LO,HDR_HI,DATA,WRITE,DONE}.
  - localparams BYTES_PER_WORD=WIDTH/8 and HDR_BYTES=2.
- One natural sub-module, word_assembler: byte shift-in, lane counter, full flag, clear.
- The FSM stays in prog_loader.

Test Plan:
- Header 0x0002, bytes 78 56 34 12 EF BE AD DE, s_valid held high -> wr_en at addr 0x0 data 0x12345678, then addr 0x4 data 0xDEADBEEF. done=1, words_written=2, cpu_hold fell the same cycle done rose.
- Header 0x0000 -> DONE right after HDR_HI. No wr_en, done=1, err=0.
- LENGTH=4, header 0x0006, 24 data bytes -> 4 writes (addr 0x0-0xC), remaining 8 bytes consumed with s_ready toggling, err=1, words_written=4, done=1.
- Random s_valid gaps (~50%) on a 3-word image -> identical write sequence to the gap-free case. s_ready=0 in every WRITE cycle.
- rst after 2 data bytes of word 1 -> next cycle all outputs 0, state IDLE. A following start plus a full 1-word image writes addr 0x0 with correct data and no stale lanes.
- start pulsed during DATA -> ignored, load completes normally. start in DONE -> reload begins, done=0, cpu_hold=1.

Source files
------------

// File: rtl/loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the program loader: FSM state encoding, header size
// and a helper that derives the number of byte lanes per memory word.
// No ports (package).
// -----------------------------------------------------------------------------
package loader_pkg;

    // Image header is a little-endian 16-bit word count.
    localparam int HDR_BYTES = 2;

    // Explicit encodings keep the state vector stable across tools and
    // readable in waveforms.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR_LO = 3'd1,
        HDR_HI = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5
    } loader_state_t;

    // Number of byte lanes in a memory word of the given bit width.
    function automatic int bytes_per_word(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/word_assembler.sv
// -----------------------------------------------------------------------------
// word_assembler
// Collects bytes into a WIDTH-bit word, little-endian (first byte -> lane 0,
// bits [7:0]). The lane counter wraps after the last lane.
//
// Ports:
//   clk      in   clock, posedge
//   rst      in   synchronous active-high reset
//   clr_i    in   drop any partial word and restart at lane 0
//   push_i   in   accept byte_i into the current lane
//   byte_i   in   8-bit data
//   word_o   out  assembled word (lanes not yet filled hold old/zero data)
//   last_o   out  push_i is filling the final lane this cycle
// -----------------------------------------------------------------------------
module word_assembler
    import loader_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [7:0]       byte_i,
    output logic [WIDTH-1:0] word_o,
    output logic             last_o
);

    localparam int BPW = bytes_per_word(WIDTH);
    localparam int LW  = (BPW > 1) ? $clog2(BPW) : 1;

    logic [LW-1:0]    lane_q, lane_d;
    logic [WIDTH-1:0] word_q, word_d;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        word_d = word_q;
        lane_d = lane_q;
        last_o = push_i && (lane_q == LW'(BPW - 1));
        if (clr_i) begin
            word_d = '0;
            lane_d = '0;
        end else if (push_i) begin
            word_d[{lane_q, 3'b000} +: 8] = byte_i;
            lane_d = last_o ? '0 : lane_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
            lane_q <= '0;
        end else begin
            word_q <= word_d;
            lane_q <= lane_d;
        end
    end

    assign word_o = word_q;

endmodule

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
// Loads a program image from a byte stream into a RAM write port while holding
// the CPU. Image = 16-bit little-endian word count, then little-endian words.
// Words go to byte addresses 0, 4, 8, ...; words beyond LENGTH are consumed
// and discarded, and err flags the oversized header.
//
// Ports:
//   clk            in   clock, posedge
//   rst            in   synchronous active-high reset
//   start          in   begin a load (honoured in IDLE and DONE only)
//   s_valid        in   byte-stream valid
//   s_data[7:0]    in   byte-stream data
//   s_ready        out  loader accepts a byte (HDR_LO, HDR_HI, DATA)
//   wr_en          out  one-cycle memory write strobe per stored word
//   wr_addr        out  word-aligned byte address of the write
//   wr_data        out  assembled word
//   cpu_hold       out  CPU stalled/flushed while a load is in progress
//   done           out  load complete (level, until next start or rst)
//   err            out  sticky: header count exceeded LENGTH
//   words_written  out  number of wr_en pulses in the current load
// -----------------------------------------------------------------------------
module prog_loader
    import loader_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int LENGTH = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             s_valid,
    input  logic [7:0]       s_data,
    output logic             s_ready,
    output logic             wr_en,
    output logic [WIDTH-1:0] wr_addr,
    output logic [WIDTH-1:0] wr_data,
    output logic             cpu_hold,
    output logic             done,
    output logic             err,
    output logic [15:0]      words_written
);

    loader_state_t state_q, state_d;
    logic [15:0]   count_q, count_d;
    logic [15:0]   idx_q, idx_d;
    logic [15:0]   ww_q, ww_d;
    logic          err_q, err_d;

    logic          xfer;
    logic          in_range;
    logic [15:0]   hdr_count;
    logic          asm_clr;
    logic          asm_last;
    logic [WIDTH-1:0] asm_word;

    assign xfer      = s_valid && s_ready;
    // Comparisons are widened to 17 bits so LENGTH up to 65536 is exact.
    assign in_range  = {1'b0, idx_q} < 17'(LENGTH);
    assign hdr_count = {s_data, count_q[7:0]};

    word_assembler #(.WIDTH(WIDTH)) u_asm (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (asm_clr),
        .push_i ((state_q == DATA) && xfer),
        .byte_i (s_data),
        .word_o (asm_word),
        .last_o (asm_last)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        ww_d    = ww_q;
        err_d   = err_q;
        asm_clr = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = HDR_LO;
                    count_d = '0;
                    idx_d   = '0;
                    ww_d    = '0;
                    err_d   = 1'b0;
                    asm_clr = 1'b1;
                end
            end
            HDR_LO: begin
                if (xfer) begin
                    count_d[7:0] = s_data;
                    state_d      = HDR_HI;
                end
            end
            HDR_HI: begin
                if (xfer) begin
                    count_d[15:8] = s_data;
                    state_d       = (hdr_count == 16'd0) ? DONE : DATA;
                    // Oversized image is still consumed to the end.
                    if ({1'b0, hdr_count} > 17'(LENGTH)) begin
                        err_d = 1'b1;
                    end
                end
            end
            DATA: begin
                if (asm_last) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (in_range) begin
                    ww_d = ww_q + 16'd1;
                end
                idx_d   = idx_q + 16'd1;
                state_d = ({1'b0, idx_q} + 17'd1 == {1'b0, count_q}) ? DONE : DATA;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            idx_q   <= '0;
            ww_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            ww_q    <= ww_d;
            err_q   <= err_d;
        end
    end

    assign s_ready       = (state_q == HDR_LO) || (state_q == HDR_HI) || (state_q == DATA);
    assign wr_en         = (state_q == WRITE) && in_range;
    assign wr_addr       = WIDTH'({idx_q, 2'b00});
    assign wr_data       = asm_word;
    assign cpu_hold      = (state_q != IDLE) && (state_q != DONE);
    assign done          = (state_q == DONE);
    assign err           = err_q;
    assign words_written = ww_q;

endmodule
